// File: rtl/mem_loader.sv
// UART boot loader: parses A5/len/data/checksum frames into 32-bit memory writes and holds the
// CPU in reset until a frame checks out. Define LOADER_TIMEOUT_EN for the inter-byte timeout.
module mem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   remaining_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        csum_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic              cpu_resetn_q;
  logic [CntW-1:0]   len_words;
  logic              last_byte;
  logic              timeout;

  // A length byte of zero selects the whole memory, hence the extra counter bit.
  always_comb begin
    len_words = CntW'(rx_data);
    if (rx_data == 8'h00) len_words[ADDR_W] = 1'b1;
  end

  assign last_byte = (state_q == StData) && rx_valid && (byte_idx_q == 2'd3);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else if (rx_valid || !busy) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end

  assign timeout = busy && !rx_valid && (idle_cnt_q == TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rx_valid && rx_data == SyncByte) state_d = StLen;
      StLen:   if (rx_valid) state_d = StData;
      StData:  if (last_byte && remaining_q == CntW'(1)) state_d = StCsum;
      StCsum:  if (rx_valid) state_d = (rx_data == csum_q) ? StDone : StErr;
      StErr:   if (rx_valid && rx_data == SyncByte) state_d = StLen;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StErr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remaining_q  <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      cpu_resetn_q <= 1'b0;
    end else begin
      wen_q <= last_byte;
      // The address moves on only once the write pulse has been presented.
      if (wen_q) addr_q <= addr_q + ADDR_W'(1);
      if (state_q == StLen && rx_valid) begin
        remaining_q <= len_words;
        byte_idx_q  <= '0;
        csum_q      <= '0;
        addr_q      <= '0;
      end
      if (state_q == StData && rx_valid) begin
        word_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
        byte_idx_q                         <= byte_idx_q + 2'd1;
        csum_q                             <= csum_q + rx_data;
        if (byte_idx_q == 2'd3) remaining_q <= remaining_q - CntW'(1);
      end
      if (state_q == StDone) cpu_resetn_q <= 1'b1;
    end
  end

  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign cpu_resetn = cpu_resetn_q;
  assign busy       = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);

endmodule
